clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Sequencing controller for the toggle-divider datapath: produces a programmable divided clock-enable waveform `div_out` from `clk`, with start/stop control, glitch-free reconfiguration at period boundaries, and a one-cycle `tick` per output period. Downstream logic uses `div_out`/`tick` as synchronous enables in the `clk` domain. Raw AND-gating of `clk` is not used.

## Interface
- `CNT_W`, default 8, width of the half-period divisor and internal counter.

- `clk` in 1, sole clock; all state updates on rising edge.
- `rst_n` in 1, asynchronous, active-low reset.
- `start` in 1, level sampled each edge; begins generation from IDLE.
- `stop` in 1, level sampled each edge; requests a clean stop.
- `cfg_valid` in 1, new divisor offered.
- `cfg_div` in CNT_W, half-period length H in `clk` cycles; 0 is treated as 1.
- `cfg_ready` out 1, controller can accept `cfg_div`; transfer occurs when `cfg_valid & cfg_ready` at an edge.
- `div_out` out 1, divided waveform, registered; period 2H, 50% duty.
- `tick` out 1, registered one-cycle pulse coincident with each 0→1 transition of `div_out`.
- `busy` out 1, high when state ≠ IDLE.

## Operation
- Reset values: state IDLE, `div_reg`=1, `cnt`=0, pending register empty, `div_out`=0, `tick`=0, `busy`=0, `cfg_ready`=1.
- Effective half-period H = max(`div_reg`,1). With H=1, `div_out` toggles every cycle, giving divide-by-2.
- States:
  - IDLE: `div_out`=0, `cnt` held at 0. A config handshake writes `div_reg` directly. `start & ~stop` → RUN with `cnt`←0.
  - RUN: `cnt` increments each edge. When `cnt`==H-1: `cnt`←0, `div_out` toggles, `tick`←1 if new `div_out`=1. `stop` with `div_out`=0 → IDLE next edge, `cnt`←0. `stop` with `div_out`=1 → DRAIN. `start` is ignored.
  - DRAIN: counting continues. At the 1→0 toggle, state → IDLE on the same edge. `start`/`stop` are ignored.
- Reconfiguration in RUN/DRAIN:
  - A config handshake loads the pending register, and `cfg_ready` drops to 0 while it is full.
  - The pending value is applied to `div_reg` on the edge where `div_out` toggles 1→0, which is the end of a full period. `cnt`←0 on that edge and `cfg_ready` returns to 1 on the next cycle.
  - If the DRAIN→IDLE edge is also the 1→0 edge, the pending value is applied there.
- Simultaneous `start` & `stop` in IDLE: stop wins, so the controller stays in IDLE.
- Counter width: `cnt` is CNT_W bits. The compare uses H-1, so `cnt` never wraps past H-1. The maximum H is 2^CNT_W-1.

## Timing
- `start` sampled at edge N → `busy`=1 after N. First `div_out` rise and `tick` occur at edge N+H. Subsequent rises occur every 2H edges.
- `tick` is high for exactly one cycle per period and is never asserted in IDLE.
- Stop latency:
  - `stop` sampled while `div_out`=0: IDLE after the next edge.
  - `stop` sampled while `div_out`=1: IDLE at the 1→0 edge, at most H edges later.
  - No truncated high phase ever occurs.
- Config in IDLE takes effect immediately: the next `start` uses the new H.
- Config in RUN takes effect at the first 1→0 edge after acceptance. Periods are never shortened mid-phase.
- `rst_n` low at any time forces all reset values immediately. A pending config is discarded. Operation resumes from IDLE on the first edge after deassertion.

## Test plan
- Reset/default: hold `rst_n`=0, release, pulse `start` at edge N → `div_out` toggles every edge from N+1, `tick` high at N+1, N+3, N+5…, `busy`=1.
- Programmed divisor: in IDLE, handshake `cfg_div`=3, then `start` at N → rises at N+3, N+9, N+15, each with a 1-cycle `tick`. Falls occur at N+6, N+12.
- Zero divisor: `cfg_div`=0 → behaviour identical to H=1.
- Live reconfig: running with H=2, handshake `cfg_div`=5 during a high phase → `cfg_ready`=0 until the next 1→0 edge. Afterwards the high and low phases are each 5 cycles. A second `cfg_valid` is not accepted while pending.
- Clean stop: H=4, assert `stop` one cycle into a high phase → DRAIN, high phase completes at 4 cycles, IDLE with `div_out`=0 and `busy`=0 on that edge. `stop` during a low phase → IDLE on the next edge. `start`+`stop` together in IDLE → remains in IDLE.
- Async reset mid-run: H=3 running with a pending config, pulse `rst_n` low between edges → outputs return to reset values without waiting for `clk`. `div_reg`=1 and the pending value is lost (verify with a subsequent `start`).

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable divided clock-enable generator with start/stop sequencing,
// clean drain-to-low stopping and reconfiguration at full-period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             div_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_pend_full;
  logic             r_div_out;
  logic             r_tick;
  logic             r_busy;
  logic             r_cfg_ready;

  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [CNT_W-1:0] w_div_nx;
  logic [CNT_W-1:0] w_pend_nx;
  logic             w_pend_full_nx;
  logic             w_div_out_nx;
  logic             w_tick_nx;
  logic             w_release;
  logic [CNT_W-1:0] w_h;
  logic             w_last;
  logic             w_hs;

  assign w_h    = (r_div == {CNT_W{1'b0}}) ? CNT_W'(1) : r_div;
  assign w_last = (r_cnt == (w_h - CNT_W'(1)));
  assign w_hs   = cfg_valid & r_cfg_ready;

  // Next-state, counter, waveform and divisor/pending-register logic.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_div_nx       = r_div;
    w_pend_nx      = r_pend;
    w_pend_full_nx = r_pend_full;
    w_div_out_nx   = r_div_out;
    w_tick_nx      = 1'b0;
    w_release      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx     = {CNT_W{1'b0}};
        w_div_out_nx = 1'b0;
        if (w_hs) begin
          w_div_nx = cfg_div;
        end else begin
          w_div_nx = r_div;
        end
        if (start & ~stop) begin
          w_state_nx = S_RUN;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop & ~r_div_out) begin
          w_state_nx   = S_IDLE;
          w_cnt_nx     = {CNT_W{1'b0}};
          w_div_out_nx = 1'b0;
          w_release    = 1'b1;
        end else if (w_last) begin
          w_cnt_nx     = {CNT_W{1'b0}};
          w_div_out_nx = ~r_div_out;
          w_tick_nx    = ~r_div_out;
          // A stop seen on the falling edge itself finishes right here.
          if (r_div_out) begin
            w_release  = 1'b1;
            w_state_nx = stop ? S_IDLE : S_RUN;
          end else begin
            w_state_nx = S_RUN;
          end
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
          w_state_nx = stop ? S_DRAIN : S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_last) begin
          w_state_nx   = S_IDLE;
          w_cnt_nx     = {CNT_W{1'b0}};
          w_div_out_nx = 1'b0;
          w_release    = 1'b1;
        end else begin
          w_cnt_nx   = r_cnt + CNT_W'(1);
          w_state_nx = S_DRAIN;
        end
      end
      default: begin
        w_state_nx     = S_IDLE;
        w_cnt_nx       = {CNT_W{1'b0}};
        w_div_out_nx   = 1'b0;
        w_pend_full_nx = 1'b0;
      end
    endcase

    // While generating, new divisors wait in the pending register; entering
    // IDLE never leaves a value stranded there.
    if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
      if (w_release) begin
        if (r_pend_full) begin
          w_div_nx       = r_pend;
          w_pend_full_nx = 1'b0;
        end else if (w_hs && (w_state_nx == S_IDLE)) begin
          w_div_nx = cfg_div;
        end else if (w_hs) begin
          w_pend_nx      = cfg_div;
          w_pend_full_nx = 1'b1;
        end else begin
          w_pend_full_nx = r_pend_full;
        end
      end else if (w_hs) begin
        w_pend_nx      = cfg_div;
        w_pend_full_nx = 1'b1;
      end else begin
        w_pend_full_nx = r_pend_full;
      end
    end else begin
      w_pend_full_nx = 1'b0;
    end
  end

  // State and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= {CNT_W{1'b0}};
      r_div       <= CNT_W'(1);
      r_pend      <= {CNT_W{1'b0}};
      r_pend_full <= 1'b0;
      r_div_out   <= 1'b0;
      r_tick      <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_div       <= w_div_nx;
      r_pend      <= w_pend_nx;
      r_pend_full <= w_pend_full_nx;
      r_div_out   <= w_div_out_nx;
      r_tick      <= w_tick_nx;
      r_busy      <= (w_state_nx != S_IDLE);
      r_cfg_ready <= ~w_pend_full_nx;
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign div_out   = r_div_out;
  assign tick      = r_tick;
  assign busy      = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: event-time reference model (absolute toggle times)
// compared every cycle, plus directed scenarios with literal expectations.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       div_out;
  logic       tick;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0=idle 1=run 2=drain, toggle at absolute edge m_tog
  int t      = 0;
  int m_mode = 0;
  int m_lvl  = 0;
  int m_tick = 0;
  int m_pful = 0;
  int m_div  = 1;
  int m_pend = 0;
  int m_tog  = 0;

  clk_div_ctrl #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .div_out   (div_out),
    .tick      (tick),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hv(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_lvl = 0; m_tick = 0; m_pful = 0; m_div = 1; m_pend = 0;
  endtask

  task automatic model_edge(input int st, input int sp, input int cv, input int cd);
    int hs, hit, fall, to_idle;
    t       = t + 1;
    hs      = (cv != 0 && m_pful == 0) ? 1 : 0;
    m_tick  = 0;
    fall    = 0;
    to_idle = 0;
    if (m_mode == 0) begin
      if (hs != 0) m_div = cd;
      if (st != 0 && sp == 0) begin
        m_mode = 1;
        m_tog  = t + hv(m_div);
      end
    end else begin
      hit = (t == m_tog) ? 1 : 0;
      if (m_mode == 1 && sp != 0 && m_lvl == 0) begin
        to_idle = 1;
      end else if (hit != 0) begin
        if (m_lvl != 0) begin
          fall  = 1;
          m_lvl = 0;
          if (m_mode == 2 || sp != 0) to_idle = 1;
        end else begin
          m_lvl  = 1;
          m_tick = 1;
        end
      end else if (m_mode == 1 && sp != 0) begin
        m_mode = 2;
      end
      if (to_idle != 0 || fall != 0) begin
        if (m_pful != 0) begin
          m_div  = m_pend;
          m_pful = 0;
        end else if (hs != 0 && to_idle != 0) begin
          m_div = cd;
        end else if (hs != 0) begin
          m_pend = cd;
          m_pful = 1;
        end
      end else if (hs != 0) begin
        m_pend = cd;
        m_pful = 1;
      end
      if (to_idle != 0) begin
        m_mode = 0;
        m_lvl  = 0;
      end else if (hit != 0) begin
        m_tog = t + hv(m_div);
      end
    end
  endtask

  task automatic step(input int st, input int sp, input int cv, input int cd);
    start     = (st != 0);
    stop      = (sp != 0);
    cfg_valid = (cv != 0);
    cfg_div   = cd[7:0];
    @(posedge clk);
    model_edge(st, sp, cv, cd);
    #1;
    chk("div_out", div_out, m_lvl);
    chk("tick", tick, m_tick);
    chk("busy", busy, (m_mode != 0) ? 1 : 0);
    chk("cfg_ready", cfg_ready, (m_pful == 0) ? 1 : 0);
  endtask

  task automatic go_idle();
    for (int i = 0; i < 40 && busy; i++) step(0, 1, 0, 0);
    chk("reach_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_div_out", div_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // default H=1: divide-by-2
    step(1, 0, 0, 0);
    chk("h1_busy", busy, 1);
    step(0, 0, 0, 0); chk("h1_rise1", div_out, 1); chk("h1_tick1", tick, 1);
    step(0, 0, 0, 0); chk("h1_fall", div_out, 0); chk("h1_notick", tick, 0);
    step(0, 0, 0, 0); chk("h1_tick2", tick, 1);
    step(0, 1, 0, 0); chk("h1_stop_busy", busy, 0); chk("h1_stop_out", div_out, 0);

    // H=3 configured in IDLE
    step(0, 0, 1, 3);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 0, 0);
      if (k == 3) chk("h3_rise_n3", tick, 1);
      if (k == 4) chk("h3_tick_once", tick, 0);
      if (k == 6) chk("h3_fall_n6", div_out, 0);
      if (k == 9) chk("h3_rise_n9", tick, 1);
    end
    go_idle();

    // zero divisor behaves as H=1
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); chk("h0_tick", tick, 1);
    step(0, 0, 0, 0); chk("h0_fall", div_out, 0);
    go_idle();

    // live reconfig 2 -> 5 during a high phase
    step(0, 0, 1, 2);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 3) step(0, 0, 1, 5);
      else if (k == 4) step(0, 0, 1, 7);
      else step(0, 0, 0, 0);
      if (k == 3) chk("rc_ready_low", cfg_ready, 0);
      if (k == 4) chk("rc_ready_back", cfg_ready, 1);
      if (k == 9) chk("rc_rise_n9", tick, 1);
      if (k == 13) chk("rc_high_n13", div_out, 1);
      if (k == 14) chk("rc_fall_n14", div_out, 0);
    end
    go_idle();

    // clean stop with H=4
    step(0, 0, 1, 4);
    step(1, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step(0, (k == 5) ? 1 : 0, 0, 0);
      if (k == 5) chk("cs_drain_out", div_out, 1);
      if (k == 7) chk("cs_drain_busy", busy, 1);
      if (k == 8) begin
        chk("cs_idle_busy", busy, 0);
        chk("cs_idle_out", div_out, 0);
      end
    end
    step(1, 1, 0, 0); chk("ss_stay_idle", busy, 0);

    // async reset with a pending config
    step(0, 0, 1, 3);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 5); chk("ar_pending", cfg_ready, 0);
    step(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out", div_out, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", cfg_ready, 1);
    chk("ar_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); chk("ar_h1_tick", tick, 1);
    go_idle();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 24) == 0,
           ($urandom % 4) == 0, $urandom_range(0, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
